// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel down-counting timer: register
// offsets within a channel window and CTRL/STATUS bit positions.
package multi_timer_pkg;

    typedef enum logic [2:0] {
        REG_RELOAD0  = 3'd0,
        REG_RELOAD1  = 3'd1,
        REG_RELOAD2  = 3'd2,
        REG_RELOAD3  = 3'd3,
        REG_CTRL     = 3'd4,
        REG_STATUS   = 3'd5,
        REG_PRESCALE = 3'd6,
        REG_RSVD     = 3'd7
    } reg_off_e;

    localparam int CTRL_START  = 0;
    localparam int CTRL_STOP   = 1;
    localparam int CTRL_AUTO   = 2;
    localparam int CTRL_IE     = 3;

    localparam int STAT_ACTIVE = 0;
    localparam int STAT_EXP    = 1;

    // Channel-select field width; a single channel still needs a 1-bit signal.
    function automatic int chan_sel_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/multi_timer_if.sv
// 8-bit CPU peripheral bus as seen by multi_timer: select, write strobe,
// address, write/read data and the merged interrupt line.
interface multi_timer_if #(
    parameter int CHANNELS = 2
);
    localparam int ADDR_W = $clog2(CHANNELS) + 3;

    logic              ce;
    logic              wren;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        from_cpu;
    logic [7:0]        to_cpu;
    logic              timer_int;

    modport master (
        output ce, wren, addr, from_cpu,
        input  to_cpu, timer_int
    );

    modport slave (
        input  ce, wren, addr, from_cpu,
        output to_cpu, timer_int
    );

endinterface

// File: rtl/multi_timer_channel.sv
// One timer channel: reload, live count, control bits, sticky expiry flag and,
// with MULTI_TIMER_PRESCALER_EN defined, an 8-bit tick prescaler.
module timer_channel
    import multi_timer_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       wr_reload,
    input  logic             wr_ctrl,
    input  logic             wr_status,
    input  logic             wr_prescale,
    input  logic [7:0]       wdata,
    output logic [WIDTH-1:0] count,
    output logic [7:0]       ctrl_rd,
    output logic [7:0]       status_rd,
    output logic [7:0]       prescale_rd,
    output logic             irq
);

    localparam int NBYTES = WIDTH / 8;

    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] count_q;
    logic             auto_q;
    logic             ie_q;
    logic             active_q;
    logic             exp_q;
    logic             tick;
    logic             start_ok;
    logic             stop;
    logic             expire;

    // STOP beats START when both strobes arrive together.
    assign stop     = wr_ctrl & wdata[CTRL_STOP];
    assign start_ok = wr_ctrl & wdata[CTRL_START] & ~wdata[CTRL_STOP] & (reload_q != '0);
    assign expire   = tick & ~stop & ~start_ok & (count_q == WIDTH'(1));

`ifdef MULTI_TIMER_PRESCALER_EN
    logic [PRESCALE_W-1:0] presc_q;
    logic [PRESCALE_W-1:0] presc_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            presc_cnt <= '0;
        end else begin
            if (wr_prescale) presc_q <= wdata[PRESCALE_W-1:0];
            if (start_ok)
                presc_cnt <= presc_q;
            else if (active_q)
                presc_cnt <= (presc_cnt == '0) ? presc_q : presc_cnt - 1'b1;
        end
    end

    assign tick        = active_q & (presc_cnt == '0);
    assign prescale_rd = 8'(presc_q);
`else
    logic unused_prescale;
    assign unused_prescale = &{1'b0, wr_prescale, PRESCALE_W[0]};
    assign tick        = active_q;
    assign prescale_rd = '0;
`endif

    // Reload bytes beyond WIDTH simply have no storage behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload_q <= '0;
        end else begin
            for (int b = 0; b < NBYTES; b++)
                if (wr_reload[b]) reload_q[8*b +: 8] <= wdata;
        end
    end

    logic unused_wr;
    assign unused_wr = &{1'b0, wr_reload};

    // NOTE: clocked state uses non-blocking assignments only, so every term on
    // the right-hand side is the value from before this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= '0;
            auto_q   <= 1'b0;
            ie_q     <= 1'b0;
            active_q <= 1'b0;
            exp_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                auto_q <= wdata[CTRL_AUTO];
                ie_q   <= wdata[CTRL_IE];
            end

            if (stop) begin
                active_q <= 1'b0;
            end else if (start_ok) begin
                count_q  <= reload_q;
                active_q <= 1'b1;
            end else if (tick) begin
                if (count_q > WIDTH'(1)) begin
                    count_q <= count_q - 1'b1;
                end else if (count_q == WIDTH'(1)) begin
                    if (auto_q) begin
                        count_q <= reload_q;
                    end else begin
                        count_q  <= '0;
                        active_q <= 1'b0;
                    end
                end
            end

            // An expiry on the same edge as a software clear keeps the flag.
            if (expire)
                exp_q <= 1'b1;
            else if (wr_status && wdata[STAT_EXP])
                exp_q <= 1'b0;
        end
    end

    assign count     = count_q;
    assign ctrl_rd   = {4'b0000, ie_q, auto_q, 2'b00};
    assign status_rd = {6'b000000, exp_q, active_q};
    assign irq       = exp_q & ie_q;

endmodule

// File: rtl/multi_timer.sv
// Multi-channel timer top: bus decode, registered read mux and interrupt OR.
// Prescalers exist only when MULTI_TIMER_PRESCALER_EN is defined.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int WIDTH      = 24,
    parameter int PRESCALE_W = 8
) (
    input logic         clk,
    input logic         rst,
    multi_timer_if.slave bus
);

    localparam int ADDR_W = $clog2(CHANNELS) + 3;
    localparam int CH_W   = chan_sel_w(CHANNELS);

    logic [CH_W-1:0]  ch_sel;
    reg_off_e         reg_off;
    logic             wr_any;
    logic [WIDTH-1:0] count_arr  [CHANNELS];
    logic [7:0]       ctrl_arr   [CHANNELS];
    logic [7:0]       status_arr [CHANNELS];
    logic [7:0]       presc_arr  [CHANNELS];
    logic [CHANNELS-1:0] irq;
    logic [31:0]      cnt32;
    logic [7:0]       rd_data;
    logic [7:0]       to_cpu_q;

    generate
        if (CHANNELS > 1) begin : g_sel
            assign ch_sel = bus.addr[ADDR_W-1:3];
        end else begin : g_nosel
            assign ch_sel = '0;
        end
    endgenerate

    assign reg_off = reg_off_e'(bus.addr[2:0]);
    assign wr_any  = bus.ce & bus.wren;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic       hit;
        logic [3:0] wr_reload;

        assign hit       = wr_any && (ch_sel == CH_W'(i));
        assign wr_reload = (hit && !bus.addr[2]) ? (4'b0001 << bus.addr[1:0]) : 4'b0000;

        timer_channel #(
            .WIDTH      (WIDTH),
            .PRESCALE_W (PRESCALE_W)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .wr_reload   (wr_reload),
            .wr_ctrl     (hit && reg_off == REG_CTRL),
            .wr_status   (hit && reg_off == REG_STATUS),
            .wr_prescale (hit && reg_off == REG_PRESCALE),
            .wdata       (bus.from_cpu),
            .count       (count_arr[i]),
            .ctrl_rd     (ctrl_arr[i]),
            .status_rd   (status_arr[i]),
            .prescale_rd (presc_arr[i]),
            .irq         (irq[i])
        );
    end

    // NOTE: rd_data gets a default before the case so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        rd_data = '0;
        cnt32   = 32'(count_arr[ch_sel]);
        case (reg_off)
            REG_RELOAD0, REG_RELOAD1,
            REG_RELOAD2, REG_RELOAD3: rd_data = cnt32[{bus.addr[1:0], 3'b000} +: 8];
            REG_CTRL:                 rd_data = ctrl_arr[ch_sel];
            REG_STATUS:               rd_data = status_arr[ch_sel];
            REG_PRESCALE:             rd_data = presc_arr[ch_sel];
            default:                  rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            to_cpu_q <= '0;
        else if (bus.ce)
            to_cpu_q <= rd_data;
    end

    assign bus.to_cpu    = to_cpu_q;
    assign bus.timer_int = |irq;

endmodule
